pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//  Next-PC sequencer between the instruction decoder and the program counter.
//  Resolves jumps, conditional branches, call/return and halt into one
//  absolute-jump request (absjump_en/target) per cycle. Also holds the PC during
//  memory stalls and while idle/halted, and flags the fetched slot for squash
//  after a taken redirect. The PC relative-jump input is not driven by this block
//  and is tied low at the PC instance.
// PARAMETERS
//  W            12  PC / target / immediate width
//  STACK_DEPTH   4  return-address stack entries (used only with RET_STACK_EN)
// PORTS
//  clk         in   1  clock, all state updates on posedge
//  reset_n     in   1  asynchronous, active-low reset
//  start       in   1  leave IDLE/HALT and begin execution at address 0
//  dec_valid   in   1  dec_op/dec_imm valid this cycle
//  dec_op      in   3  000 none, 001 jrel, 010 jabs, 011 brc (cond rel), 100 call, 101 ret, 110 halt
//  dec_imm     in   W  jrel/brc: two's-complement offset; jabs/call: absolute target
//  cond_flag   in   1  branch condition for brc (taken when 1)
//  mem_stall   in   1  instruction memory not ready; freeze sequencing
//  prog_ctr    in   W  current PC value
//  absjump_en  out  1  PC loads target at next posedge
//  target      out  W  next PC when absjump_en=1
//  flush       out  1  instruction fetched this cycle is invalid (squash)
//  busy        out  1  state is RUN or FLUSH
//  done        out  1  state is HALT
//  error       out  1  sticky: illegal op or stack over/underflow
// BEHAVIOUR
//  - States: IDLE, RUN, FLUSH, HALT. During reset: IDLE, sp=0, error=0.
//  - absjump_en/target/flush are combinational from state and inputs. They are
//    sampled by the PC on the same edge, so a redirect decoded in cycle n gives
//    prog_ctr=target after edge n (0-cycle added latency).
//  - Outputs while reset_n=0: absjump_en=1, target=prog_ctr, flush=0, busy=0,
//    done=0, error=0.
//  - Hold = absjump_en=1, target=prog_ctr. Hold is asserted in IDLE, in HALT,
//    and whenever mem_stall=1 in RUN/FLUSH.
//  - IDLE/HALT: start=1 -> absjump_en=1, target=0, next state RUN. done is 1
//    only in HALT. start is ignored in RUN/FLUSH.
//  - RUN with mem_stall=1: hold. dec_* are ignored; the decoder keeps them
//    stable until the stall clears. State and stack are unchanged.
//  - RUN with mem_stall=0 and dec_valid=1:
//      jrel:           target = prog_ctr + sext(dec_imm), mod 2^W.
//      brc, cond_flag=1: same as jrel. brc, cond_flag=0: no redirect.
//      jabs:           target = dec_imm.
//      call:           push prog_ctr+1 (mod 2^W), target = dec_imm.
//      ret:            target = pop.
//      halt:           hold, next state HALT.
//      none / no dec_valid: absjump_en=0 (PC increments).
//  - Any redirect (absjump_en=1 from a taken op) -> next state FLUSH.
//  - FLUSH: flush=1 for exactly one unstalled cycle. dec_valid is ignored.
//    With mem_stall=1, stay in FLUSH with flush=1 and PC held.
//    With mem_stall=0, PC increments and next state is RUN.
//  - Wrap-around: target arithmetic and return address wrap modulo 2^W, with
//    no error.
//  - Stack full + call: push dropped, error=1, jump still taken.
//  - Stack empty + ret: error=1, no redirect, stay in RUN.
//  - dec_op 111: illegal. error=1, treated as none.
//  - Reset mid-operation: state, sp and error clear immediately, asynchronously.
// CONFIGURATION
//  RET_STACK_EN defined: STACK_DEPTH-entry LIFO return stack. sp width is
//    $clog2(STACK_DEPTH+1). call/ret behave as above.
//  RET_STACK_EN undefined: no stack storage. call and ret are illegal: error=1,
//    no redirect, no push/pop.
// TESTING
//  1. reset_n=0 mid-RUN -> outputs take reset values immediately. start -> target=0, busy=1.
//  2. RUN, pc=0x010, jrel imm=0xFFC -> target=0x00C, next cycle flush=1, then PC increments.
//  3. brc imm=0x005 at pc=0x020: cond_flag=0 -> absjump_en=0. cond_flag=1 -> target=0x025.
//  4. mem_stall=1 for 3 cycles with a pending jabs 0x300 -> target=prog_ctr held 3 cycles,
//     then target=0x300.
//  5. RET_STACK_EN: call 0x100 at pc=0x040, ret -> target=0x041.
//     STACK_DEPTH+1 calls -> error=1. ret on empty -> error=1, no redirect.
//  6. halt at pc=0x0FF -> done=1, PC frozen 10 cycles. start -> target=0, RUN.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer between the instruction decoder and the PC.
// Every jump, taken branch, call, return, halt and stall becomes one
// absolute-jump request (absjump_en/target) that the PC samples on the same
// edge. The cycle after a taken redirect is flagged for squash via flush.
// Optional feature macro: RET_STACK_EN. When it is defined, the block has a
// STACK_DEPTH-entry return-address stack. When it is not defined, call and ret
// are illegal ops.
module pc_seq_ctrl #(
    parameter int W           = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         dec_valid,
    input  logic [2:0]   dec_op,
    input  logic [W-1:0] dec_imm,
    input  logic         cond_flag,
    input  logic         mem_stall,
    input  logic [W-1:0] prog_ctr,
    output logic         absjump_en,
    output logic [W-1:0] target,
    output logic         flush,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    localparam logic [2:0] OP_JREL = 3'b001;
    localparam logic [2:0] OP_JABS = 3'b010;
    localparam logic [2:0] OP_BRC  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    if (STACK_DEPTH < 1) begin : g_depth_check
        $error("pc_seq_ctrl: STACK_DEPTH must be at least 1");
    end

    state_t       state;
    state_t       state_nxt;
    logic         abs_c;
    logic         flush_c;
    logic         err_set;
    logic [W-1:0] tgt_c;

`ifdef RET_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [W-1:0]     stack_mem [STACK_DEPTH];
    logic             push;
    logic             pop;
    logic             stack_full;
    logic             stack_empty;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    // Indices are only used while the stack is not full (push) or not empty (pop).
    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - 1'b1);
`endif

    // Decode the current state and decoder op into this cycle's PC request and next state.
    always_comb begin
        state_nxt = state;
        abs_c     = 1'b0;
        tgt_c     = prog_ctr;
        flush_c   = 1'b0;
        err_set   = 1'b0;
`ifdef RET_STACK_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif
        case (state)
            IDLE, HALT: begin
                // The PC is held here until start. Then the PC restarts at address 0.
                abs_c = 1'b1;
                if (start) begin
                    tgt_c     = '0;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (mem_stall)
                    abs_c = 1'b1;
                else
                    state_nxt = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    abs_c = 1'b1;
                end else if (dec_valid) begin
                    case (dec_op)
                        OP_JREL: begin
                            abs_c     = 1'b1;
                            tgt_c     = prog_ctr + dec_imm;
                            state_nxt = FLUSH;
                        end
                        OP_BRC: begin
                            if (cond_flag) begin
                                abs_c     = 1'b1;
                                tgt_c     = prog_ctr + dec_imm;
                                state_nxt = FLUSH;
                            end
                        end
                        OP_JABS: begin
                            abs_c     = 1'b1;
                            tgt_c     = dec_imm;
                            state_nxt = FLUSH;
                        end
`ifdef RET_STACK_EN
                        OP_CALL: begin
                            // When the stack is full, the push is dropped but the call still jumps.
                            abs_c     = 1'b1;
                            tgt_c     = dec_imm;
                            state_nxt = FLUSH;
                            if (stack_full)
                                err_set = 1'b1;
                            else
                                push = 1'b1;
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                err_set = 1'b1;
                            end else begin
                                pop       = 1'b1;
                                abs_c     = 1'b1;
                                tgt_c     = stack_mem[top_idx];
                                state_nxt = FLUSH;
                            end
                        end
`else
                        OP_CALL, OP_RET: err_set = 1'b1;
`endif
                        OP_HALT: begin
                            abs_c     = 1'b1;
                            state_nxt = HALT;
                        end
                        OP_ILL:  err_set = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // While reset is asserted, the outputs force a PC hold regardless of the inputs.
    assign absjump_en = reset_n ? abs_c : 1'b1;
    assign target     = reset_n ? tgt_c : prog_ctr;
    assign flush      = reset_n & flush_c;

    // State register with registered status outputs and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
`ifdef RET_STACK_EN
            sp    <= '0;
`endif
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN) || (state_nxt == FLUSH);
            done  <= (state_nxt == HALT);
            if (err_set)
                error <= 1'b1;
`ifdef RET_STACK_EN
            if (push)
                sp <= sp + 1'b1;
            else if (pop)
                sp <= sp - 1'b1;
`endif
        end
    end

`ifdef RET_STACK_EN
    // Return-address storage. The return address wraps modulo 2^W.
    always_ff @(posedge clk) begin
        if (push)
            stack_mem[push_idx] <= prog_ctr + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Testbench for pc_seq_ctrl. The bench owns the program counter and drives
// prog_ctr from its own prediction of each cycle's jump request.
module tb_pc_seq_ctrl;

    localparam int W     = 12;
    localparam int DEPTH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         dec_valid = 1'b0;
    logic [2:0]   dec_op = 3'd0;
    logic [W-1:0] dec_imm = '0;
    logic         cond_flag = 1'b0;
    logic         mem_stall = 1'b0;
    logic [W-1:0] pc = '0;
    logic         absjump_en;
    logic [W-1:0] target;
    logic         flush;
    logic         busy;
    logic         done;
    logic         error;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state
    int  mode = M_IDLE;
    bit  merr = 1'b0;
`ifdef RET_STACK_EN
    logic [W-1:0] rs[$];
`endif

    // DUT outputs observed in the most recent cycle
    logic         obs_abs;
    logic [W-1:0] obs_tgt;
    logic         obs_flush;
    logic         obs_busy;
    logic         obs_done;
    logic         obs_error;

    pc_seq_ctrl #(.W(W), .STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dec_valid  (dec_valid),
        .dec_op     (dec_op),
        .dec_imm    (dec_imm),
        .cond_flag  (cond_flag),
        .mem_stall  (mem_stall),
        .prog_ctr   (pc),
        .absjump_en (absjump_en),
        .target     (target),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] imm,
                         input logic c, input logic s, input logic st);
        dec_valid = v;
        dec_op    = op;
        dec_imm   = imm;
        cond_flag = c;
        mem_stall = s;
        start     = st;
    endtask

    // Called just after a negedge. The task predicts and checks this cycle,
    // advances the model and the PC past the posedge, and returns at the next negedge.
    task automatic do_cycle();
        logic         e_abs;
        logic         e_flush;
        logic [W-1:0] e_tgt;
        int           nxt;
        bit           e_err;
        #1;
        e_abs   = 1'b0;
        e_flush = 1'b0;
        e_tgt   = pc;
        nxt     = mode;
        e_err   = 1'b0;
        if (mode == M_IDLE || mode == M_HALT) begin
            e_abs = 1'b1;
            if (start) begin
                e_tgt = '0;
                nxt   = M_RUN;
            end
        end else if (mode == M_FLUSH) begin
            e_flush = 1'b1;
            if (mem_stall) e_abs = 1'b1;
            else nxt = M_RUN;
        end else if (mem_stall) begin
            e_abs = 1'b1;
        end else if (dec_valid) begin
            case (dec_op)
                3'd1: begin e_abs = 1'b1; e_tgt = pc + dec_imm; nxt = M_FLUSH; end
                3'd3: if (cond_flag) begin e_abs = 1'b1; e_tgt = pc + dec_imm; nxt = M_FLUSH; end
                3'd2: begin e_abs = 1'b1; e_tgt = dec_imm; nxt = M_FLUSH; end
`ifdef RET_STACK_EN
                3'd4: begin
                    e_abs = 1'b1; e_tgt = dec_imm; nxt = M_FLUSH;
                    if (rs.size() == DEPTH) e_err = 1'b1;
                    else rs.push_back(pc + 12'd1);
                end
                3'd5: begin
                    if (rs.size() == 0) e_err = 1'b1;
                    else begin e_abs = 1'b1; e_tgt = rs.pop_back(); nxt = M_FLUSH; end
                end
`else
                3'd4, 3'd5: e_err = 1'b1;
`endif
                3'd6: begin e_abs = 1'b1; nxt = M_HALT; end
                3'd7: e_err = 1'b1;
                default: ;
            endcase
        end
        obs_abs   = absjump_en;
        obs_tgt   = target;
        obs_flush = flush;
        obs_busy  = busy;
        obs_done  = done;
        obs_error = error;
        chk("absjump_en", absjump_en, e_abs);
        if (e_abs) chk("target", target, e_tgt);
        chk("flush", flush, e_flush);
        chk("busy", busy, (mode == M_RUN || mode == M_FLUSH));
        chk("done", done, (mode == M_HALT));
        chk("error", error, merr);
        @(posedge clk);
        #1;
        mode = nxt;
        if (e_err) merr = 1'b1;
        pc = e_abs ? e_tgt : pc + 12'd1;
        @(negedge clk);
    endtask

    // Asserts reset for one cycle and checks that the outputs respond asynchronously.
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_absjump_en", absjump_en, 1);
        chk("rst_target", target, pc);
        chk("rst_flush", flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        mode = M_IDLE;
        merr = 1'b0;
`ifdef RET_STACK_EN
        rs.delete();
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held;

        // Reset state and start from IDLE
        apply_reset();
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        drive(0, 3'd0, '0, 0, 0, 1);
        do_cycle();
        chk("t1_start_target", obs_tgt, 12'h000);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        chk("t1_busy", obs_busy, 1);

        // Backward relative jump followed by one flush cycle
        pc = 12'h010;
        drive(1, 3'd1, 12'hFFC, 0, 0, 0);
        do_cycle();
        chk("t2_target", obs_tgt, 12'h00C);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        chk("t2_flush", obs_flush, 1);
        chk("t2_flush_inc", obs_abs, 0);
        do_cycle();
        chk("t2_run_noflush", obs_flush, 0);

        // Conditional branch, not taken and then taken
        pc = 12'h020;
        drive(1, 3'd3, 12'h005, 0, 0, 0);
        do_cycle();
        chk("t3_not_taken", obs_abs, 0);
        pc = 12'h020;
        drive(1, 3'd3, 12'h005, 1, 0, 0);
        do_cycle();
        chk("t3_taken_target", obs_tgt, 12'h025);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();

        // Absolute jump held off by three stall cycles
        held = pc;
        drive(1, 3'd2, 12'h300, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            chk("t4_stall_hold", obs_tgt, held);
        end
        drive(1, 3'd2, 12'h300, 0, 0, 0);
        do_cycle();
        chk("t4_jabs_target", obs_tgt, 12'h300);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();

`ifdef RET_STACK_EN
        // Call and return, then stack overflow and underflow
        pc = 12'h040;
        drive(1, 3'd4, 12'h100, 0, 0, 0);
        do_cycle();
        chk("t5_call_target", obs_tgt, 12'h100);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        drive(1, 3'd5, '0, 0, 0, 0);
        do_cycle();
        chk("t5_ret_target", obs_tgt, 12'h041);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1, 3'd4, 12'h200, 0, 0, 0);
            do_cycle();
            chk("t5_call_jumps", obs_abs, 1);
            drive(0, 3'd0, '0, 0, 0, 0);
            do_cycle();
        end
        chk("t5_overflow_error", obs_error, 1);
        apply_reset();
        drive(0, 3'd0, '0, 0, 0, 1);
        do_cycle();
        drive(1, 3'd5, '0, 0, 0, 0);
        do_cycle();
        chk("t5_underflow_noredirect", obs_abs, 0);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        chk("t5_underflow_error", obs_error, 1);
        chk("t5_underflow_stay_run", obs_flush, 0);
`else
        // call and ret are illegal without the return stack
        drive(1, 3'd4, 12'h100, 0, 0, 0);
        do_cycle();
        chk("t5_call_illegal", obs_abs, 0);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        chk("t5_call_error", obs_error, 1);
        apply_reset();
        drive(0, 3'd0, '0, 0, 0, 1);
        do_cycle();
        drive(1, 3'd5, '0, 0, 0, 0);
        do_cycle();
        chk("t5_ret_illegal", obs_abs, 0);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        chk("t5_ret_error", obs_error, 1);
`endif

        // Halt freezes the PC until the next start
        pc = 12'h0FF;
        drive(1, 3'd6, '0, 0, 0, 0);
        do_cycle();
        chk("t6_halt_hold", obs_tgt, 12'h0FF);
        drive(0, 3'd0, '0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            do_cycle();
            chk("t6_done", obs_done, 1);
            chk("t6_frozen", obs_tgt, 12'h0FF);
        end
        drive(0, 3'd0, '0, 0, 0, 1);
        do_cycle();
        chk("t6_restart_target", obs_tgt, 12'h000);
        drive(0, 3'd0, '0, 0, 0, 0);
        do_cycle();
        chk("t6_restart_busy", obs_busy, 1);

        // Reset in the middle of RUN
        drive(0, 3'd0, '0, 0, 0, 1);
        apply_reset();
        drive(0, 3'd0, '0, 0, 0, 1);
        do_cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
            end else begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 6));
                if ($urandom_range(0, 49) == 0) op = 3'd7;
                drive(($urandom_range(0, 3) != 0), op, W'($urandom),
                      1'($urandom), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 3) == 0));
                do_cycle();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
